cache_port_sequencer: RTL and testbench

Two-port request sequencer in front of the direct-mapped data cache. It arbitrates between two read requesters (round-robin), drives the cache lookup, and on a miss fetches the full line from main memory word by word, writing each word into the cache. It then re-looks-up the address and returns a one-cycle ready pulse to the granted requester. It replaces the single-requester hit/miss controller as the block that sequences the cache datapath.

---
 rtl/cache_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/cache_port_sequencer.sv | 133 +++++++++++++
 tb/tb_cache_port_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache request sequencer.
package cache_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_HIT    = 2'd3
    } state_t;

    // Clears the word-offset bits; callers truncate back to their address width.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
        return addr & ~(32'(line_words) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; last_grant only moves when a served request completes.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic       grant_o
);

    logic last_grant_q;

    // On a tie the port not served last wins; otherwise the lone requester wins.
    always_comb begin
        if (req_i == 2'b11) grant_o = ~last_grant_q;
        else                grant_o = req_i[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          last_grant_q <= 1'b1;
        else if (update_i) last_grant_q <= served_i;
    end

endmodule

// File: rtl/cache_port_sequencer.sv
// Two-port round-robin read sequencer with line refill in front of a direct-mapped cache.
// Optional miss counter port enabled by defining CACHE_MISS_COUNT_EN.
module cache_port_sequencer
    import cache_pkg::*;
#(
    parameter  int ADDR_W     = DEF_ADDR_W,
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    localparam int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ready0,
    output logic              ready1,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              hit,
    output logic              read_enable,
    output logic              write_enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    output logic              busy,
`ifdef CACHE_MISS_COUNT_EN
    output logic [15:0]       miss_count,
`endif
    output state_t            dbg_state,
    output logic [CNT_W-1:0]  dbg_word_cnt
);

    // Handshake: reqN is a level held until readyN pulses for one cycle; the
    // requester drops req on the edge that samples ready, else it is re-served.
    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               port_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               grant;
    logic [ADDR_W-1:0]  refill_addr;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({req1, req0}),
        .update_i (state_q == ST_HIT),
        .served_i (port_q),
        .grant_o  (grant)
    );

    assign refill_addr = ADDR_W'(line_base(32'(addr_q), LINE_WORDS)) | ADDR_W'(word_cnt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            port_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        port_q  <= grant;
                        addr_q  <= grant ? addr1 : addr0;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        state_q <= ST_HIT;
                    end else begin
                        state_q    <= ST_REFILL;
                        word_cnt_q <= '0;
                    end
                end
                ST_REFILL: begin
                    if (mem_valid) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (word_cnt_q == CNT_W'(LINE_WORDS - 1)) state_q <= ST_LOOKUP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write strobe follows mem_valid in the same cycle, so outputs decode the live state.
    always_comb begin
        cache_addr   = '0;
        mem_addr     = '0;
        mem_req      = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_LOOKUP: cache_addr = addr_q;
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = refill_addr;
                if (mem_valid) begin
                    write_enable = 1'b1;
                    cache_addr   = refill_addr;
                end
            end
            ST_HIT: begin
                read_enable = 1'b1;
                cache_addr  = addr_q;
                ready0      = ~port_q;
                ready1      = port_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_MISS_COUNT_EN
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            miss_cnt_q <= '0;
        else if (state_q == ST_LOOKUP && !hit && miss_cnt_q != 16'hFFFF)
            miss_cnt_q <= miss_cnt_q + 16'd1;
    end

    assign miss_count = miss_cnt_q;
`endif

    assign dbg_state    = state_q;
    assign dbg_word_cnt = word_cnt_q;

endmodule

// File: tb/tb_cache_port_sequencer.sv
// Directed bench for cache_port_sequencer: arbitration, hit/miss timing, stalls, reset mid-refill.
module tb_cache_port_sequencer;
    import cache_pkg::*;

    localparam int AW = 15;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          ready0, ready1;
    logic [AW-1:0] cache_addr;
    logic          hit = 1'b0;
    logic          read_enable, write_enable, mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid = 1'b0;
    logic          busy;
`ifdef CACHE_MISS_COUNT_EN
    logic [15:0]   miss_count;
`endif
    state_t        dbg_state;
    logic [1:0]    dbg_word_cnt;

    logic [AW-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    cache_port_sequencer #(.ADDR_W(AW), .LINE_WORDS(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .addr0        (addr0),
        .addr1        (addr1),
        .ready0       (ready0),
        .ready1       (ready1),
        .cache_addr   (cache_addr),
        .hit          (hit),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .busy         (busy),
`ifdef CACHE_MISS_COUNT_EN
        .miss_count   (miss_count),
`endif
        .dbg_state    (dbg_state),
        .dbg_word_cnt (dbg_word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_memreq"}, 32'(mem_req), 32'd0);
        check({tag, "_memaddr"}, 32'(mem_addr), 32'd0);
        check({tag, "_caddr"}, 32'(cache_addr), 32'd0);
        check({tag, "_we"}, 32'(write_enable), 32'd0);
        check({tag, "_re"}, 32'(read_enable), 32'd0);
        check({tag, "_rdy"}, 32'({ready1, ready0}), 32'd0);
        check({tag, "_wcnt"}, 32'(dbg_word_cnt), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Full transaction from IDLE; misses get one memory-latency cycle then back-to-back beats.
    task automatic run_txn(input string tag, input logic port, input logic [AW-1:0] addr,
                           input logic [AW-1:0] exp_base, input logic miss);
        if (port) begin req1 = 1'b1; addr1 = addr; end
        else      begin req0 = 1'b1; addr0 = addr; end
        hit = ~miss;
        step();
        if (miss) begin
            step();
            #1 check({tag, "_base"}, 32'(mem_addr), 32'(exp_base));
            for (int b = 0; b < LW; b++) begin
                step();
                mem_valid = 1'b1;
            end
            step();
            mem_valid = 1'b0;
            hit = 1'b1;
        end
        step();
        #1 check({tag, "_ready"}, 32'({ready1, ready0}), port ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step();
        #1 check_quiet("rst");
        step();
        rst = 1'b1;
        step();

        // Tie with both requests held: port 0 first, then alternate
        req0 = 1'b1; addr0 = 15'h0050;
        req1 = 1'b1; addr1 = 15'h0060;
        hit = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            #1 check("tie_lookup_addr", 32'(cache_addr), (g == 1) ? 32'h60 : 32'h50);
            step();
            #1 check("tie_ready", 32'({ready1, ready0}), (g == 1) ? 32'd2 : 32'd1);
            if (g == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
            #1 check("tie_gap_busy", 32'(busy), 32'd0);
        end

        // Hit on port 0; mem_valid during LOOKUP must be ignored
        req0 = 1'b1; addr0 = 15'h0010; hit = 1'b1;
        step();
        mem_valid = 1'b1;
        #1 check("hit_lookup_state", 32'(dbg_state), 32'(ST_LOOKUP));
        check("hit_lookup_we", 32'(write_enable), 32'd0);
        check("hit_lookup_rdy", 32'(ready0), 32'd0);
        step();
        mem_valid = 1'b0;
        #1 check("hit_ready0", 32'(ready0), 32'd1);
        check("hit_re", 32'(read_enable), 32'd1);
        check("hit_caddr", 32'(cache_addr), 32'h0010);
        req0 = 1'b0;
        step();
        #1 check("hit_idle_busy", 32'(busy), 32'd0);

        // Miss on port 1 with back-to-back memory beats
        req1 = 1'b1; addr1 = 15'h0123; hit = 1'b0;
        exp_q = {15'h0120, 15'h0121, 15'h0122, 15'h0123};
        step();
        #1 check("miss_lookup_caddr", 32'(cache_addr), 32'h0123);
        step();
        #1 check("miss_c2_memreq", 32'(mem_req), 32'd1);
        check("miss_c2_memaddr", 32'(mem_addr), 32'h0120);
        check("miss_c2_we", 32'(write_enable), 32'd0);
        for (int b = 0; b < LW; b++) begin
            logic [AW-1:0] e;
            step();
            mem_valid = 1'b1;
            e = exp_q.pop_front();
            #1 check("miss_we", 32'(write_enable), 32'd1);
            check("miss_memaddr", 32'(mem_addr), 32'(e));
            check("miss_caddr", 32'(cache_addr), 32'(e));
        end
        step();
        mem_valid = 1'b0;
        hit = 1'b1;
        #1 check("miss_relookup_state", 32'(dbg_state), 32'(ST_LOOKUP));
        check("miss_relookup_memreq", 32'(mem_req), 32'd0);
        step();
        #1 check("miss_ready_c8", 32'({ready1, ready0}), 32'd2);
        check("miss_ready_caddr", 32'(cache_addr), 32'h0123);
        req1 = 1'b0;
        step();

        // Stalled memory: 3 idle cycles between beats
        req0 = 1'b1; addr0 = 15'h0206; hit = 1'b0;
        step();
        step();
        for (int b = 0; b < LW; b++) begin
            step();
            mem_valid = 1'b1;
            #1 check("stall_beat_we", 32'(write_enable), 32'd1);
            check("stall_beat_addr", 32'(mem_addr), 32'h0204 + 32'(b));
            if (b < LW - 1) begin
                for (int g = 0; g < 3; g++) begin
                    step();
                    mem_valid = 1'b0;
                    #1 check("stall_gap_we", 32'(write_enable), 32'd0);
                    check("stall_gap_wcnt", 32'(dbg_word_cnt), 32'(b + 1));
                    check("stall_gap_memreq", 32'(mem_req), 32'd1);
                end
            end
        end
        step();
        mem_valid = 1'b0;
        hit = 1'b1;
        #1 check("stall_no_early_ready", 32'(ready0), 32'd0);
        step();
        #1 check("stall_ready0", 32'(ready0), 32'd1);
        req0 = 1'b0;
        step();

        // Top-of-range address: line base wraps down to 0x7FFC
        run_txn("maxaddr", 1'b1, 15'h7FFF, 15'h7FFC, 1'b1);

        // Reset asserted mid-refill after two beats
        req1 = 1'b1; addr1 = 15'h0300; hit = 1'b0;
        step();
        step();
        for (int b = 0; b < 2; b++) begin
            step();
            mem_valid = 1'b1;
        end
        step();
        mem_valid = 1'b0;
        #1 check("rstmid_wcnt_before", 32'(dbg_word_cnt), 32'd2);
        check("rstmid_addr_before", 32'(mem_addr), 32'h0302);
        rst = 1'b0;
        req1 = 1'b0;
        #1 check_quiet("rstmid");
        step();
        step();
        rst = 1'b1;
        step();
        req0 = 1'b1; addr0 = 15'h0040; hit = 1'b0;
        step();
        #1 check("post_rst_lookup", 32'(dbg_state), 32'(ST_LOOKUP));
        step();
        #1 check("post_rst_memaddr", 32'(mem_addr), 32'h0040);
        check("post_rst_wcnt", 32'(dbg_word_cnt), 32'd0);
        for (int b = 0; b < LW; b++) begin
            step();
            mem_valid = 1'b1;
        end
        step();
        mem_valid = 1'b0;
        hit = 1'b1;
        step();
        #1 check("post_rst_ready0", 32'(ready0), 32'd1);
        req0 = 1'b0;
        step();

`ifdef CACHE_MISS_COUNT_EN
        rst = 1'b0;
        step();
        #1 check("mc_reset", 32'(miss_count), 32'd0);
        rst = 1'b1;
        step();
        run_txn("mc_m0", 1'b0, 15'h0400, 15'h0400, 1'b1);
        run_txn("mc_m1", 1'b1, 15'h0405, 15'h0404, 1'b1);
        run_txn("mc_m2", 1'b0, 15'h040B, 15'h0408, 1'b1);
        run_txn("mc_h0", 1'b1, 15'h0400, 15'h0400, 1'b0);
        #1 check("mc_three", 32'(miss_count), 32'd3);
        dut.miss_cnt_q = 16'hFFFF;
        step();
        run_txn("mc_sat", 1'b0, 15'h0500, 15'h0500, 1'b1);
        #1 check("mc_saturate", 32'(miss_count), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
